// File: rtl/graph_chk_pkg.sv
// Shared types and the golden logic model for the graph response checker.
package graph_chk_pkg;

   localparam int Q_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      CHECK = 2'd2
   } chk_state_t;

   // Expected {q4,q3,q2,q1} of the graph design for a given d1/d2/d3.
   function automatic logic [Q_W-1:0] expected_q(input logic d1, input logic d2, input logic d3);
      logic n5;
      logic n6;
      logic n3;
      n5 = d1 & d2;
      n6 = d2 | ~d3;
      n3 = ~d3;
      return {n6, ~(n5 | n3), ~(n5 & n6), n5};
   endfunction

endpackage

// File: rtl/graph_response_checker_if.sv
// d->q bus between the stimulus/design-under-test side and the checker.
interface graph_response_checker_if;

   // No handshake: every signal is a level sampled on each rising clk edge.
   logic d1;
   logic d2;
   logic d3;
   logic q1;
   logic q2;
   logic q3;
   logic q4;

   modport master (output d1, d2, d3, q1, q2, q3, q4);
   modport slave  (input  d1, d2, d3, q1, q2, q3, q4);

endinterface

// File: rtl/graph_chk_counter.sv
// Saturating, synchronously clearable up-counter.
module graph_chk_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/graph_response_checker.sv
// Compares observed q1..q4 against the golden model of the previous cycle's d1..d3,
// counting samples/errors and latching the first failing bit pattern.
module graph_response_checker
   import graph_chk_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     clear,
   graph_response_checker_if.slave  bus,
   output logic                     mismatch,
   output logic [Q_W-1:0]           mismatch_vec,
   output logic [Q_W-1:0]           first_fail_vec,
   output logic                     fail,
   output logic [CNT_W-1:0]         sample_count,
   output logic [CNT_W-1:0]         err_count,
   output logic                     busy,
   output chk_state_t               state_dbg
);

   chk_state_t     state;
   chk_state_t     state_nxt;
   logic           do_cmp;
   logic           load_exp;
   logic [Q_W-1:0] exp_q;
   logic [Q_W-1:0] q_obs;
   logic [Q_W-1:0] diff;

   assign q_obs     = {bus.q4, bus.q3, bus.q2, bus.q1};
   assign diff      = exp_q ^ q_obs;
   assign busy      = (state == ARM) || (state == CHECK);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      do_cmp    = 1'b0;
      load_exp  = 1'b0;
      case (state)
         IDLE: begin
            if (en) state_nxt = ARM;
         end
         ARM: begin
            load_exp  = 1'b1;
            state_nxt = en ? CHECK : IDLE;
         end
         CHECK: begin
            load_exp = 1'b1;
            // Leaving CHECK discards this cycle's compare.
            if (en) do_cmp    = 1'b1;
            else    state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q <= '0;
      end else if (load_exp) begin
         exp_q <= expected_q(bus.d1, bus.d2, bus.d3);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mismatch       <= 1'b0;
         mismatch_vec   <= '0;
         first_fail_vec <= '0;
         fail           <= 1'b0;
      end else if (clear) begin
         mismatch       <= 1'b0;
         mismatch_vec   <= '0;
         first_fail_vec <= '0;
         fail           <= 1'b0;
      end else if (do_cmp) begin
         mismatch     <= |diff;
         mismatch_vec <= diff;
         if ((|diff) && !fail) begin
            fail           <= 1'b1;
            first_fail_vec <= diff;
         end
      end else begin
         mismatch <= 1'b0;
      end
   end

   graph_chk_counter #(.CNT_W(CNT_W)) u_sample_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (do_cmp),
      .count (sample_count)
   );

   graph_chk_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (do_cmp && (|diff)),
      .count (err_count)
   );

endmodule

// File: tb/tb_graph_response_checker.sv
// Directed bench for graph_response_checker with a 16-bit and a 2-bit counter instance.
module tb_graph_response_checker;
   import graph_chk_pkg::*;

   logic clk;
   logic rst;
   logic en;
   logic clear;

   graph_response_checker_if bus ();

   logic        mismatch;
   logic [3:0]  mismatch_vec;
   logic [3:0]  first_fail_vec;
   logic        fail;
   logic [15:0] sample_count;
   logic [15:0] err_count;
   logic        busy;
   chk_state_t  st;

   logic        s_mismatch;
   logic [3:0]  s_mismatch_vec;
   logic [3:0]  s_first_fail_vec;
   logic        s_fail;
   logic [1:0]  s_sample_count;
   logic [1:0]  s_err_count;
   logic        s_busy;
   chk_state_t  s_st;

   int n_tests;
   int n_fail;

   graph_response_checker #(.CNT_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .clear          (clear),
      .bus            (bus.slave),
      .mismatch       (mismatch),
      .mismatch_vec   (mismatch_vec),
      .first_fail_vec (first_fail_vec),
      .fail           (fail),
      .sample_count   (sample_count),
      .err_count      (err_count),
      .busy           (busy),
      .state_dbg      (st)
   );

   graph_response_checker #(.CNT_W(2)) dut_sat (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .clear          (clear),
      .bus            (bus.slave),
      .mismatch       (s_mismatch),
      .mismatch_vec   (s_mismatch_vec),
      .first_fail_vec (s_first_fail_vec),
      .fail           (s_fail),
      .sample_count   (s_sample_count),
      .err_count      (s_err_count),
      .busy           (s_busy),
      .state_dbg      (s_st)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] d, input logic [3:0] q);
      bus.d1 = d[2];
      bus.d2 = d[1];
      bus.d3 = d[0];
      bus.q1 = q[0];
      bus.q2 = q[1];
      bus.q3 = q[2];
      bus.q4 = q[3];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] all_out();
      return {21'd0, mismatch, mismatch_vec, first_fail_vec, fail, sample_count, err_count, busy};
   endfunction

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst   = 1'b0;
      en    = 1'b0;
      clear = 1'b0;
      drive(3'b000, 4'b0000);
      #1;
      check("reset_outputs", all_out(), 64'd0);
      check("reset_state", 64'(st), 64'(IDLE));
      tick();
      tick();
      rst = 1'b1;

      // idle with random stimulus: nothing may move
      for (int i = 0; i < 10; i++) begin
         drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
         tick();
         check("idle_outputs", all_out(), 64'd0);
      end

      // matching stream
      en = 1'b1;
      tick();
      check("arm_state", 64'(st), 64'(ARM));
      check("arm_busy", 64'(busy), 64'd1);
      drive(3'b110, 4'b0000);
      tick();
      check("arm_no_compare", 64'(sample_count), 64'd0);
      check("check_state", 64'(st), 64'(CHECK));
      drive(3'b000, 4'b1001);
      tick();
      check("match1_sc", 64'(sample_count), 64'd1);
      check("match1_mm", 64'(mismatch), 64'd0);
      drive(3'b001, 4'b1010);
      tick();
      drive(3'b000, 4'b0110);
      tick();
      check("match_sc", 64'(sample_count), 64'd3);
      check("match_ec", 64'(err_count), 64'd0);
      check("match_fail", 64'(fail), 64'd0);

      // injected faults
      drive(3'b110, 4'b1010);
      tick();
      check("pre_fault_mm", 64'(mismatch), 64'd0);
      drive(3'b000, 4'b1000);
      tick();
      check("fault_mm", 64'(mismatch), 64'd1);
      check("fault_vec", 64'(mismatch_vec), 64'h1);
      check("fault_first", 64'(first_fail_vec), 64'h1);
      check("fault_fail", 64'(fail), 64'd1);
      check("fault_ec", 64'(err_count), 64'd1);
      check("fault_sc", 64'(sample_count), 64'd5);
      drive(3'b000, 4'b1010);
      tick();
      check("after_fault_mm", 64'(mismatch), 64'd0);
      check("after_fault_vec", 64'(mismatch_vec), 64'h0);
      check("after_fault_first", 64'(first_fail_vec), 64'h1);
      check("after_fault_fail", 64'(fail), 64'd1);
      drive(3'b000, 4'b0101);
      tick();
      check("fault2_vec", 64'(mismatch_vec), 64'hf);
      check("fault2_first", 64'(first_fail_vec), 64'h1);
      check("fault2_ec", 64'(err_count), 64'd2);
      drive(3'b000, 4'b1010);
      tick();
      check("fault2_pulse", 64'(mismatch), 64'd0);
      en = 1'b0;
      drive(3'b111, 4'b0000);
      tick();
      check("exit_state", 64'(st), 64'(IDLE));
      check("exit_no_compare", 64'(sample_count), 64'd8);
      check("exit_busy", 64'(busy), 64'd0);

      // saturation on the 2-bit instance
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_sc", 64'(sample_count), 64'd0);
      check("clear_fail", 64'(fail), 64'd0);
      check("clear_sat_ec", 64'(s_err_count), 64'd0);
      en = 1'b1;
      tick();
      drive(3'b110, 4'b0000);
      tick();
      for (int i = 1; i <= 5; i++) begin
         drive(3'b110, 4'b0110);
         tick();
         if (i == 3) begin
            check("sat3_ec", 64'(s_err_count), 64'h3);
            check("sat3_sc", 64'(s_sample_count), 64'h3);
         end
      end
      check("sat5_ec", 64'(s_err_count), 64'h3);
      check("sat5_sc", 64'(s_sample_count), 64'h3);
      check("sat5_fail", 64'(s_fail), 64'd1);
      check("sat5_first", 64'(s_first_fail_vec), 64'hf);
      check("sat5_mm", 64'(s_mismatch), 64'd1);
      check("wide5_ec", 64'(err_count), 64'd5);
      check("wide5_sc", 64'(sample_count), 64'd5);

      // clear coincident with a failing compare
      drive(3'b110, 4'b0110);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_cmp_outputs", all_out() & ~64'd1, 64'd0);
      check("clr_cmp_state", 64'(st), 64'(CHECK));
      drive(3'b110, 4'b1001);
      tick();
      check("clr_next_sc", 64'(sample_count), 64'd1);
      check("clr_next_ec", 64'(err_count), 64'd0);

      // async reset between edges
      drive(3'b110, 4'b0110);
      tick();
      check("pre_rst_ec", 64'(err_count), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_outputs", all_out(), 64'd0);
      check("async_rst_state", 64'(st), 64'(IDLE));
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      check("rearm_state", 64'(st), 64'(ARM));
      drive(3'b110, 4'b1001);
      tick();
      check("rearm_no_compare", 64'(sample_count), 64'd0);
      tick();
      check("rearm_first_sc", 64'(sample_count), 64'd1);
      check("rearm_first_mm", 64'(mismatch), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/graph_response_checker.md
# graph_response_checker

- Cycle-accurate output checker for the graph delete/modify regression design.
- Samples the same d1/d2/d3 stimulus that drives the design under test and computes the expected register outputs q1..q4 from a golden logic model.
- Compares them one cycle later against the observed q1..q4, then counts samples and mismatches and latches the first failing bit pattern.
- Sits beside the design under test in the graph test harness, on the output-consuming end of its d→q interface.

## Interface
- CNT_W, 16, width of sample and error counters (≥2)
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  checking enable; level-sensitive
- clear  input  1  synchronous clear of counters, sticky flags and first-fail capture
- d1, d2, d3  input  1 each  stimulus as applied to the design under test
- q1, q2, q3, q4  input  1 each  observed design-under-test register outputs
- mismatch  output  1  one-cycle pulse per failing compare
- mismatch_vec  output  4  bit i−1 = qi differed in the last compare; held until the next compare
- first_fail_vec  output  4  mismatch_vec of the first failure since reset/clear
- fail  output  1  sticky; set on first mismatch
- sample_count  output  CNT_W  compares performed, saturating
- err_count  output  CNT_W  failing compares, saturating
- busy  output  1  high in ARM or CHECK

## Operation
- Golden model, with n5=d1&d2, n6=d2|~d3, n3=~d3:
  - exp[0]=n5
  - exp[1]=~(n5&n6)
  - exp[2]=~(n5|n3)
  - exp[3]=n6
- FSM states: IDLE, ARM, CHECK.
  - IDLE: no compares. When en=1 → ARM.
  - ARM: capture exp into exp_q, which is the only action in this state. en=1 → CHECK; en=0 → IDLE.
  - CHECK: every cycle, compare {q4,q3,q2,q1} against exp_q, and recapture exp_q from the current d.
    - Compare result at edge N+1 reflects d sampled at edge N−1 against q sampled at edge N (register latency 1).
    - en=0 → IDLE with no compare that cycle; the next activation passes through ARM again.
- Compare effects, registered at the edge following the compare cycle:
  - mismatch_vec = exp_q ^ q.
  - mismatch = |(exp_q ^ q).
  - sample_count is incremented.
  - err_count is incremented only if mismatch.
  - First failure while fail=0: set fail and load first_fail_vec.
- Saturation: a counter at all-ones stays all-ones. Saturation never wraps and never alters fail.
- clear:
  - Zeroes the counters, fail, first_fail_vec and mismatch_vec, and drops mismatch.
  - Does not change FSM state. A compare in the same cycle is discarded.
  - clear has priority over every counter and flag update.
- Reset mid-operation: all state returns to reset values immediately, with no clock needed.

## Timing
- Reset values:
  - FSM = IDLE.
  - All outputs 0, including sample_count, err_count, first_fail_vec, mismatch_vec, fail and busy.
- Reset deasserts synchronously to clk externally; the block tolerates deassertion on any edge.
- Latency: stimulus at edge N → compare output visible after edge N+2.
- mismatch is never high for more than one cycle unless consecutive compares fail.
- busy reflects the registered FSM state.
- en rising → first compare result two edges later (ARM, then the first CHECK edge).

## Structure
- Package graph_chk_pkg holds:
  - state enum chk_state_t {IDLE, ARM, CHECK};
  - the localparam Q_W=4;
  - the function expected_q(d1,d2,d3) returning logic [3:0].
- One sub-module, graph_chk_counter: a saturating, clearable CNT_W counter with an inc input. It is instantiated twice, once for samples and once for errors.
- FSM, exp_q, compare and flag logic live in graph_response_checker.

## Test plan
- Reset/idle: rst=0 then 1, en=0, random d/q for 10 cycles → all outputs stay 0, busy=0.
- Matching stream: en=1 with d=(1,1,0), then (0,0,0), then (0,0,1); q follows one cycle later at 4'b1001, 4'b1010, 4'b0110 → sample_count=3, err_count=0, fail=0.
- Injected fault: d=(1,1,0), q next cycle = 4'b1000 → mismatch pulse, mismatch_vec=4'b0001, first_fail_vec=4'b0001, fail=1, err_count=1. A later matching sample leaves first_fail_vec unchanged.
- Saturation: CNT_W=2, 5 failing compares → err_count=2'b11 and sample_count=2'b11 after the third, held through the fifth.
- clear coincident with a failing compare → counters, flags and vectors are 0 on the next cycle. The FSM stays in CHECK and the next compare counts as 1.
- Async reset asserted mid-CHECK, between edges → outputs 0 immediately. After release with en=1, ARM is re-entered before any compare.
